load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Sits downstream of the single-cycle datapath, between its ALU result / store data and a
//  handshaked data memory with variable latency. Formats stores (SB/SH/SW byte enables and
//  lane replication) and loads (LB/LH/LW/LBU/LHU lane select and sign/zero extension).
//  Asserts stall so the datapath holds PC and the instruction until the access completes,
//  then returns readData for write-back.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max REQ cycles waiting for memAck before busErr; 0 = never time out
//  CNT_W           8    width of the timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   synchronous reset, active low
//  memRead    in   1   load instruction present (datapath control)
//  memWrite   in   1   store instruction present; wins over memRead if both are set
//  funct3     in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  addr       in   32  byte address (datapath ALUResultOut)
//  writeData  in   32  store data (datapath writeData, rs2)
//  readData   out  32  formatted load data, valid in the DONE cycle
//  stall      out  1   hold PC/regfile write; combinational
//  busErr     out  1   one-cycle pulse: timeout or illegal funct3
//  misaligned out  1   one-cycle pulse: misaligned access (LSU_MISALIGN_TRAP_EN only)
//  memReq     out  1   memory request, held until memAck
//  memWe      out  1   1 = write
//  memAddr    out  32  word-aligned address ({addr[31:2],2'b00})
//  memWdata   out  32  lane-replicated store data
//  memBe      out  4   byte enables
//  memAck     in   1   completion; sampled only in REQ
//  memRdata   in   32  read word, valid with memAck
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): state IDLE, counter 0; memReq, memWe, busErr, misaligned = 0;
//    readData, memAddr, memWdata = 0; memBe = 0. Reset in REQ abandons the access; late memAck is ignored.
//  - FSM IDLE->REQ->DONE->IDLE.
//    IDLE: op = memRead|memWrite. If op and legal: stall=1; register addr, memWe, memBe, memWdata
//    and funct3; go to REQ. No op: stall=0.
//    REQ: memReq=1, stall=1, counter++. On memAck: capture formatted memRdata into readData
//    (loads only; stores leave it unchanged); go to DONE. If counter==TIMEOUT_CYCLES (and not 0)
//    without ack: memReq drops, readData=0, busErr=1 in the DONE cycle.
//    DONE: stall=0, memReq=0, and the datapath commits. Always returns to IDLE next cycle.
//    The instruction present in DONE is the same one and must not re-issue.
//  - Minimum latency with memAck in the first REQ cycle: stall high 2 cycles, data in cycle 3.
//  - Stores: SB memBe=4'b0001<<addr[1:0], data={4{wd[7:0]}}. SH memBe=addr[1]?1100:0011,
//    data={2{wd[15:0]}}. SW memBe=1111.
//  - Loads: byte lane=addr[1:0], half lane=addr[1]. B/H sign-extend; BU/HU zero-extend.
//  - funct3 011/110/111 with op: no access, stall=0, busErr=1 that cycle, FSM stays IDLE.
//  - memAck in IDLE or DONE: ignored.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: H with addr[0]=1, or W with addr[1:0]!=0, gives no access,
//   stall=0, misaligned=1 for that cycle, readData=0.
//  LSU_MISALIGN_TRAP_EN undefined: low address bits are ignored for the lane (H uses addr[1], W the
//   full word) and the access proceeds. misaligned is tied to 0.
// TESTING
//  SW addr=0x104 wd=0xDEADBEEF, ack after 3 REQ cycles -> memBe=1111, memAddr=0x104, stall high 4 cycles
//  LB addr=0x103, memRdata=0x80FF_FFFF, immediate ack -> readData=0xFFFFFF80; LBU -> 0x00000080
//  SH addr=0x102 wd=0x1234 -> memBe=1100, memWdata=0x12341234; LHU same addr, rdata 0xABCD0000 -> 0x0000ABCD
//  LW, never acked, TIMEOUT_CYCLES=4 -> memReq drops after 4 REQ cycles, busErr pulse, readData=0, back to IDLE
//  LW addr=0x101: TRAP_EN -> misaligned=1, memReq never 1; without -> word 0x100 is read
//  rst_n low during REQ, then memAck -> outputs 0 and IDLE; funct3=111 -> single busErr pulse

Source files
------------

// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit: variable-latency req/ack bus.
// master = LSU side, slave = memory side.
interface load_store_unit_if;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memBe;
  logic        memAck;
  logic [31:0] memRdata;

  modport master (
    output memReq, memWe, memAddr, memWdata, memBe,
    input  memAck, memRdata
  );

  modport slave (
    input  memReq, memWe, memAddr, memWdata, memBe,
    output memAck, memRdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: store lane formatting, load extraction, stall and timeout.
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of issuing.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     memRead,
  input  logic                     memWrite,
  input  logic [2:0]               funct3,
  input  logic [31:0]              addr,
  input  logic [31:0]              writeData,
  output logic [31:0]              readData,
  output logic                     stall,
  output logic                     busErr,
  output logic                     misaligned,
  load_store_unit_if.master        mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               TO_EN  = (TIMEOUT_CYCLES != 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lo_q, lo_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              op;
  logic              legal;
  logic              is_word;
  logic              is_half;
  logic              mis_hit;
  logic              mis_pulse;
  logic              req;
  logic [3:0]        st_be;
  logic [31:0]       st_wd;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       ld_val;

  assign op      = memRead | memWrite;
  assign is_word = (funct3[1:0] == 2'b10);
  assign is_half = (funct3[1:0] == 2'b01);

  always_comb begin
    legal = 1'b1;
    case (funct3)
      3'b011, 3'b110, 3'b111: legal = 1'b0;
      default:                legal = 1'b1;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_hit = (is_half & addr[0]) | (is_word & (|addr[1:0]));
`else
  assign mis_hit = 1'b0;
`endif

  always_comb begin
    st_be = 4'b0001 << addr[1:0];
    st_wd = {4{writeData[7:0]}};
    unique case (1'b1)
      is_word: begin
        st_be = 4'b1111;
        st_wd = writeData;
      end
      is_half: begin
        st_be = addr[1] ? 4'b1100 : 4'b0011;
        st_wd = {2{writeData[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_v = mem.memRdata[7:0];
    case (lo_q)
      2'd1:    byte_v = mem.memRdata[15:8];
      2'd2:    byte_v = mem.memRdata[23:16];
      2'd3:    byte_v = mem.memRdata[31:24];
      default: byte_v = mem.memRdata[7:0];
    endcase
  end

  assign half_v = lo_q[1] ? mem.memRdata[31:16] : mem.memRdata[15:0];

  // f3_q[2] marks the unsigned variants
  always_comb begin
    case (f3_q[1:0])
      2'b10:   ld_val = mem.memRdata;
      2'b01:   ld_val = {{16{half_v[15] & ~f3_q[2]}}, half_v};
      default: ld_val = {{24{byte_v[7] & ~f3_q[2]}}, byte_v};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    lo_d      = lo_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    stall     = 1'b0;
    busErr    = 1'b0;
    mis_pulse = 1'b0;
    req       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (op) begin
          if (!legal) begin
            busErr = 1'b1;
          end else if (mis_hit) begin
            mis_pulse = 1'b1;
          end else begin
            stall   = 1'b1;
            we_d    = memWrite;
            be_d    = st_be;
            addr_d  = {addr[31:2], 2'b00};
            wdata_d = st_wd;
            f3_d    = funct3;
            lo_d    = addr[1:0];
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        req   = 1'b1;
        stall = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (mem.memAck) begin
          if (!we_q) rdata_d = ld_val;
          state_d = DONE;
        end else if (TO_EN && (cnt_d == TO_VAL)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busErr  = err_q;
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign readData     = mis_pulse ? '0 : rdata_q;
  assign misaligned   = mis_pulse;
  assign mem.memReq   = req;
  assign mem.memWe    = we_q;
  assign mem.memBe    = be_q;
  assign mem.memAddr  = addr_q;
  assign mem.memWdata = wdata_q;

endmodule
